// File: rtl/simon_pkg.sv
// ============================================================================
// Module   : simon_pkg
// Purpose  : Shared constants and state encoding for the Simon-128/128
//            round sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

   // Number of rounds for the 128/128 parameter set
   localparam int SIMON_ROUNDS_128 = 68;

   // z2 round-constant sequence; the datapath indexes it with rnd_idx mod 62
   localparam logic [61:0] SIMON_Z2 =
      62'b10101111011100000011010010011000101000010001111110010110110011;

   // Controller state encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } simon_state_e;

   // Plain-vector aliases of the encoding for the FSM register
   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_LOAD = S_LOAD;
   localparam logic [1:0] ST_RUN  = S_RUN;
   localparam logic [1:0] ST_DONE = S_DONE;

endpackage

`default_nettype wire

// File: rtl/simon_round_ctrl_if.sv
// ============================================================================
// Module   : simon_round_ctrl_if
// Purpose  : Host handshake and datapath strobe bundle for simon_round_ctrl.
//            slave = controller side, master = host/datapath side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simon_round_ctrl_if;
   logic       en;
   logic       drdy;
   logic       bsy;
   logic       dvld;
   logic       trig;
   logic       dp_load;
   logic       dp_rnd_en;
   logic       dp_key_en;
   logic       dp_out_en;
   logic [6:0] rnd_idx;
   logic [2:0] phase;

   modport slave (
      input  en, drdy,
      output bsy, dvld, trig, dp_load, dp_rnd_en, dp_key_en, dp_out_en,
             rnd_idx, phase
   );

   modport master (
      output en, drdy,
      input  bsy, dvld, trig, dp_load, dp_rnd_en, dp_key_en, dp_out_en,
             rnd_idx, phase
   );
endinterface

`default_nettype wire

// File: rtl/simon_rnd_cnt.sv
// ============================================================================
// Module   : simon_rnd_cnt
// Purpose  : Sub-cycle phase and round index counter pair. phase wraps at
//            CPR-1; rnd_idx saturates at ROUNDS-1 so it still reads the last
//            round after completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_rnd_cnt
   import simon_pkg::*;
#(
   parameter int ROUNDS = SIMON_ROUNDS_128,
   parameter int CPR    = 1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       clr,
   input  wire logic       adv,
   output logic [2:0]      phase,
   output logic [6:0]      rnd_idx,
   output logic            phase_tc,
   output logic            rnd_last
);

   localparam logic [2:0] C_PH_LAST  = 3'(CPR - 1);
   localparam logic [6:0] C_RND_LAST = 7'(ROUNDS - 1);

   logic [2:0] r_phase;
   logic [6:0] r_rnd;

   assign phase    = r_phase;
   assign rnd_idx  = r_rnd;
   assign phase_tc = (r_phase == C_PH_LAST);
   assign rnd_last = (r_rnd == C_RND_LAST);

   // Clear on load, otherwise step phase and carry into the round index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= 3'd0;
         r_rnd   <= 7'd0;
      end else if (clr) begin
         r_phase <= 3'd0;
         r_rnd   <= 7'd0;
      end else if (adv) begin
         if (phase_tc) begin
            r_phase <= 3'd0;
            if (!rnd_last)
               r_rnd <= r_rnd + 7'd1;
         end else begin
            r_phase <= r_phase + 3'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/simon_round_ctrl.sv
// ============================================================================
// Module   : simon_round_ctrl
// Purpose  : Sequencing FSM for the Simon-128/128 round datapath. Issues
//            load / round / key / output strobes, tracks the round index and
//            drives the scope trigger. Holds no cipher data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_round_ctrl
   import simon_pkg::*;
#(
   parameter int ROUNDS = SIMON_ROUNDS_128,
   parameter int CPR    = 1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   simon_round_ctrl_if.slave  bus
);

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       w_run_act;
   logic       w_rnd_step;
   logic       w_cnt_clr;
   logic       w_phase_tc;
   logic       w_rnd_last;

   // EN low freezes everything, so every strobe is qualified by it
   assign w_run_act  = bus.en && (r_state == ST_RUN);
   assign w_rnd_step = w_run_act && w_phase_tc;
   assign w_cnt_clr  = bus.en && (r_state == ST_LOAD);

   simon_rnd_cnt #(
      .ROUNDS (ROUNDS),
      .CPR    (CPR)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_cnt_clr),
      .adv      (w_run_act),
      .phase    (bus.phase),
      .rnd_idx  (bus.rnd_idx),
      .phase_tc (w_phase_tc),
      .rnd_last (w_rnd_last)
   );

   // Next-state decode; EN low holds the current state
   always_comb begin
      w_next = r_state;
      if (bus.en) begin
         case (r_state)
            ST_IDLE: if (bus.drdy) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_RUN;
            ST_RUN:  if (w_phase_tc && w_rnd_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Outputs decoded from registered state only (plus the EN qualifier)
   assign bus.bsy       = (r_state != ST_IDLE);
   assign bus.dp_load   = bus.en && (r_state == ST_LOAD);
   assign bus.dp_rnd_en = w_rnd_step;
   assign bus.dp_key_en = w_rnd_step && !w_rnd_last;
   assign bus.dvld      = bus.en && (r_state == ST_DONE);
   assign bus.dp_out_en = bus.en && (r_state == ST_DONE);
   assign bus.trig      = bus.en && ((r_state == ST_LOAD) ||
                          ((r_state == ST_RUN) && (bus.rnd_idx == 7'd0)));

endmodule

`default_nettype wire

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Sequencing controller for the Simon-128/128 round datapath, including the unprotected and threshold-shared variants. It sits between the SASEBO host handshake (Drdy/Dvld/BSY/EN) and the round/key-schedule registers. It issues the load, round-step, key-step and output-capture strobes, tracks the round index, and raises the scope trigger. It holds no cipher data.

## Interface
- ROUNDS, 68: number of Simon rounds (128/128).
- CPR, 1: clock cycles per round (>1 for pipelined threshold AND stages); range 1..8.
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  global enable; low freezes all counters and suppresses every strobe.
- Drdy  in  1  host data-ready; starts an encryption when sampled high in IDLE with EN=1.
- BSY  out  1  high from LOAD through DONE inclusive.
- Dvld  out  1  one-cycle pulse in DONE: result valid on the datapath output register.
- Trig  out  1  scope trigger, high during LOAD and the first round.
- dp_load  out  1  datapath captures plaintext/key shares from Din.
- dp_rnd_en  out  1  state register advances one round.
- dp_key_en  out  1  key-schedule register advances (dp_rnd_en except on the last round).
- dp_out_en  out  1  output register captures final state (same cycle as Dvld).
- rnd_idx  out  7  current round 0..ROUNDS-1, selects z-constant bit.
- phase  out  3  sub-cycle within the round, 0..CPR-1.

## Operation
- States: IDLE, LOAD, RUN, DONE (encoding in package).
- IDLE: If Drdy=1 and EN=1, go to LOAD. Otherwise stay.
- LOAD: Lasts one cycle. dp_load=1. Clear rnd_idx and phase. Go to RUN.
- RUN: phase counts 0..CPR-1. dp_rnd_en=1 when phase=CPR-1. At that point phase wraps to 0 and rnd_idx increments.
- RUN exit: When rnd_idx=ROUNDS-1 and phase=CPR-1, the final round step fires and the state goes to DONE. rnd_idx does not wrap and holds ROUNDS-1.
- dp_key_en is low on the final round step. The key register keeps the last round key.
- DONE: Lasts one cycle. Dvld=1 and dp_out_en=1. Go to IDLE. rnd_idx holds until the next LOAD.
- EN=0 in any state: state, rnd_idx and phase hold. dp_* strobes, Dvld and Trig are forced 0. BSY keeps its state-derived value.
- Drdy while BSY=1 is ignored. No queueing.
- Drdy sampled in the DONE cycle is ignored. A new start needs Drdy high in IDLE.
- All outputs are combinational from registered state/counters. They are glitch-free per cycle.

## Timing
- Reset values: state=IDLE, rnd_idx=0, phase=0, and every output 0.
- RST asserted mid-run returns to IDLE immediately. No Dvld is produced. The datapath contents are don't-care.
- Cycle numbering: cycle 0 is the cycle in which Drdy=1 is sampled in IDLE. LOAD is cycle 1. RUN occupies cycles 2..1+ROUNDS*CPR. DONE is cycle 2+ROUNDS*CPR. IDLE resumes at cycle 3+ROUNDS*CPR.
- Defaults: Dvld in cycle 70, and 69 dp_rnd_en pulses are not produced; exactly 68 are.
- With EN low, each stalled cycle shifts all later events by one.
- Trig is high for cycles 1..1+CPR, i.e. LOAD plus the first round.
- Throughput: back-to-back starts are possible with Drdy held high. The next LOAD occurs at cycle 4+ROUNDS*CPR.

## Structure
- Package simon_pkg holds:
  - the state enum;
  - SIMON_ROUNDS_128 = 68;
  - the z2 constant (62 bits), indexed rnd_idx mod 62 by the datapath, not by this block.
- Optional sub-module simon_rnd_cnt: the phase/rnd_idx counter pair with wrap and terminal-count outputs. The FSM stays in simon_round_ctrl.
- Target 150-250 lines of RTL.

## Test plan
- Defaults, reset, single Drdy pulse with EN=1 -> dp_load in cycle 1; 68 dp_rnd_en pulses in cycles 2..69; 67 dp_key_en pulses; Dvld=dp_out_en=1 in cycle 70 only; BSY high in cycles 1..70; rnd_idx reads 67 at Dvld.
- CPR=3 -> dp_rnd_en once every 3 cycles, when phase=2; Dvld in cycle 206; Trig high in cycles 1..4.
- EN dropped for 5 cycles at round 10 -> no strobes during the drop; rnd_idx stays 10; Dvld delayed to cycle 75.
- Drdy pulsed at cycles 20 and 70 during a run -> ignored; exactly one Dvld; no second dp_load until Drdy is high in IDLE.
- RST pulsed at cycle 30 -> all outputs 0 asynchronously; state IDLE; no Dvld; a subsequent Drdy gives a full 70-cycle run.
- Drdy held high continuously -> LOAD at cycles 1, 72, 143, …; exactly one Dvld per run.
